tile_row_buffer: RTL
====================

Name: tile_row_buffer

Overview:
Sits directly downstream of the SPAD tile reader and consumes its (address, data, valid, read-done) stream. It packs incoming words row-major into one bank of a ROWS x COLS ping-pong register buffer. It presents completed tiles one row per handshake to the PE-array row loader. It throttles and restarts the tile reader through enable and clear outputs.

Parameters:
ADDR_WIDTH, 8, SPAD address width (matches tile reader)
DATA_WIDTH, 8, word width
ROWS, 4, rows per tile bank
COLS, 4, words per row (PE array width)

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_en  in  1  block enable; low = writer FSM holds in IDLE
i_reg_clear  in  1  synchronous clear to reset state
i_base_addr  in  ADDR_WIDTH  tile start address, for address check
i_row_len  in  ADDR_WIDTH  words per row, legal 1..COLS; 0 or >COLS treated as COLS
i_addr  in  ADDR_WIDTH  word address from tile reader
i_data  in  DATA_WIDTH  word data from tile reader
i_data_valid  in  1  word valid
i_read_done  in  1  tile reader finished tile (level)
o_reader_en  out  1  enable to tile reader
o_reader_clear  out  1  one-cycle clear pulse to tile reader
o_row_data  out  COLS*DATA_WIDTH  row being presented; col 0 in LSBs
o_row_idx  out  $clog2(ROWS)  index of presented row
o_row_valid  out  1  row valid
i_row_ready  in  1  downstream accepts row
o_row_last  out  1  presented row is ROWS-1
o_overflow  out  1  sticky: word arrived with row counter >= ROWS
o_addr_err  out  1  sticky: i_addr != i_base_addr + word count at a valid word

Behaviour:
- Reset and i_reg_clear set all outputs to 0. They also clear both banks to 0, full[1:0]=0, wr_bank=0, rd_bank=0, and all counters to 0. i_reg_clear has priority over every other event.
- Writer FSM states: IDLE, FILL, DRAIN, COMMIT, STALL.
- IDLE: when i_en=1 and full[wr_bank]=0, go to FILL; otherwise stay.
- FILL: o_reader_en=1. Each i_data_valid word is written to bank[wr_bank][row_cnt][col_cnt] when row_cnt<ROWS; otherwise it is dropped and o_overflow is set.
  - col_cnt wraps to 0 at eff_row_len-1, and row_cnt then increments. row_cnt saturates at ROWS.
  - word_cnt increments per valid word, modulo 2^ADDR_WIDTH.
  - The address compare uses the pre-increment word_cnt.
  - When i_read_done=1, go to DRAIN; a valid word in that same cycle is still written.
- DRAIN: exactly one cycle with o_reader_en=0. This absorbs the 1-cycle SPAD latency, so a valid word here is written normally. Next state is COMMIT.
- COMMIT: set full[wr_bank]=1 and pulse o_reader_clear=1 for this single cycle. Zero counters and toggle wr_bank.
  - If the new wr_bank is not full and i_en=1, go to FILL.
  - Else if the new wr_bank is full, go to STALL.
  - Else (new wr_bank not full, i_en=0), go to IDLE.
- STALL: o_reader_en=0. Leave to FILL the cycle after full[wr_bank] reads 0. Full flags are registered, so there is a one-cycle bubble after a release.
- Before its first write in FILL, a bank's cells are cleared to 0. Unwritten cells of a partial tile therefore read 0.
- Reader side: o_row_valid = full[rd_bank]. o_row_data is row rd_row of bank[rd_bank], registered and updated on each row advance. o_row_idx = rd_row. o_row_last = (rd_row==ROWS-1).
  - On o_row_valid & i_row_ready, rd_row increments.
  - On the last row's handshake: full[rd_bank] is cleared, rd_bank toggles, and rd_row returns to 0.
  - Every tile emits all ROWS rows.
  - o_row_data and o_row_idx hold stable while o_row_valid=1 and i_row_ready=0.
- Simultaneous COMMIT setting one bank and a handshake releasing the other are independent and both take effect.
- i_en dropping mid-FILL does not abort the tile; it only prevents leaving IDLE.
- Async reset mid-operation discards both banks.

Test Plan:
1. Single tile: ROWS=COLS=4, i_row_len=4, base=0x10, 16 words 0x10..0x1F at 0x10..0x1F, done, ready=1 -> rows idx0..3 carry {0x13,0x12,0x11,0x10}...{0x1F..0x1C}; o_reader_clear pulses once; o_row_last on idx3; no err flags.
2. Short rows: i_row_len=3, 9 words 1..9 -> row0={0,3,2,1}, row1={0,6,5,4}, row2={0,9,8,7}, row3=0; o_row_valid for 4 handshakes.
3. Ping-pong stall: i_row_ready=0, three tiles issued -> after two COMMITs, STALL with o_reader_en=0. Release row 3 of bank 0 -> FILL resumes exactly 2 cycles after the handshake edge.
4. Late word: valid word 0xAA arrives in the DRAIN cycle as the 16th word -> stored at row3 col3; no overflow.
5. Faults: 17 words -> o_overflow=1, 17th dropped. Word 5 presented at base+6 -> o_addr_err=1 sticky until i_reg_clear.
6. Mid-fill async reset after 7 words -> all outputs 0, o_row_valid stays 0. A subsequent clean tile is emitted correctly.

Source files
------------

// File: rtl/tile_row_buffer.sv
// Packs a tile reader word stream row-major into a ROWS x COLS ping-pong buffer and presents finished tiles one row per handshake.
// A committed tile is visible 1 cycle after COMMIT. The writer stalls the tile reader while both banks are full; rows hold stable until accepted.
module tile_row_buffer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 4
) (
   input  logic                          i_clk,
   input  logic                          i_nrst,
   input  logic                          i_en,
   input  logic                          i_reg_clear,
   input  logic [ADDR_WIDTH-1:0]         i_base_addr,
   input  logic [ADDR_WIDTH-1:0]         i_row_len,
   input  logic [ADDR_WIDTH-1:0]         i_addr,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_data_valid,
   input  logic                          i_read_done,
   output logic                          o_reader_en,
   output logic                          o_reader_clear,
   output logic [COLS*DATA_WIDTH-1:0]    o_row_data,
   output logic [$clog2(ROWS)-1:0]       o_row_idx,
   output logic                          o_row_valid,
   input  logic                          i_row_ready,
   output logic                          o_row_last,
   output logic                          o_overflow,
   output logic                          o_addr_err
);

   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RCW = $clog2(ROWS + 1);
   localparam int RIW = $clog2(ROWS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_COMMIT,
      S_STALL
   } state_t;

   state_t                                            r_state;
   logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]         r_bank [2];
   logic [1:0]                                        r_full;
   logic                                              r_wr_bank;
   logic                                              r_rd_bank;
   logic [RCW-1:0]                                    r_row_cnt;
   logic [CW-1:0]                                     r_col_cnt;
   logic [ADDR_WIDTH-1:0]                             r_word_cnt;
   logic [RIW-1:0]                                    r_rd_row;
   logic                                              r_release;
   logic                                              r_reader_en;
   logic                                              r_reader_clear;
   logic                                              r_overflow;
   logic                                              r_addr_err;
   logic [COLS*DATA_WIDTH-1:0]                        r_row_data;

   logic [ADDR_WIDTH-1:0]                             w_eff_len;
   logic                                              w_col_last;
   logic                                              w_accept;
   logic                                              w_room;
   logic                                              w_commit;
   logic                                              w_hs;
   logic                                              w_hs_last;
   logic                                              w_other_bank;
   logic [1:0]                                        w_full_nxt;
   logic                                              w_rd_bank_nxt;
   logic [RIW-1:0]                                    w_rd_row_nxt;
   logic [COLS*DATA_WIDTH-1:0]                        w_row_sel;

   // Out-of-range row lengths fall back to a full PE-array row.
   always_comb begin
      w_eff_len = i_row_len;
      if (i_row_len == '0 || i_row_len > ADDR_WIDTH'(COLS)) begin
         w_eff_len = ADDR_WIDTH'(COLS);
      end
   end

   assign w_col_last   = (ADDR_WIDTH'(r_col_cnt) == w_eff_len - ADDR_WIDTH'(1));
   assign w_accept     = i_data_valid && (r_state == S_FILL || r_state == S_DRAIN);
   assign w_room       = (r_row_cnt < RCW'(ROWS));
   assign w_commit     = (r_state == S_COMMIT);
   assign w_other_bank = ~r_wr_bank;
   assign w_hs         = r_full[r_rd_bank] & i_row_ready;
   assign w_hs_last    = w_hs && (r_rd_row == RIW'(ROWS - 1));

   always_comb begin
      w_full_nxt = r_full;
      if (w_commit) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_hs_last) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   assign w_rd_bank_nxt = w_hs_last ? ~r_rd_bank : r_rd_bank;
   assign w_rd_row_nxt  = w_hs_last ? '0 : (w_hs ? r_rd_row + RIW'(1) : r_rd_row);
   assign w_row_sel     = r_bank[w_rd_bank_nxt][w_rd_row_nxt];

   // Writer FSM; reader enable/clear are registered alongside the state.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state        <= S_IDLE;
         r_bank[0]      <= '0;
         r_bank[1]      <= '0;
         r_wr_bank      <= 1'b0;
         r_row_cnt      <= '0;
         r_col_cnt      <= '0;
         r_word_cnt     <= '0;
         r_release      <= 1'b0;
         r_reader_en    <= 1'b0;
         r_reader_clear <= 1'b0;
         r_overflow     <= 1'b0;
         r_addr_err     <= 1'b0;
      end else if (i_reg_clear) begin
         r_state        <= S_IDLE;
         r_bank[0]      <= '0;
         r_bank[1]      <= '0;
         r_wr_bank      <= 1'b0;
         r_row_cnt      <= '0;
         r_col_cnt      <= '0;
         r_word_cnt     <= '0;
         r_release      <= 1'b0;
         r_reader_en    <= 1'b0;
         r_reader_clear <= 1'b0;
         r_overflow     <= 1'b0;
         r_addr_err     <= 1'b0;
      end else begin
         r_reader_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_en && !r_full[r_wr_bank]) begin
                  r_state           <= S_FILL;
                  r_reader_en       <= 1'b1;
                  r_bank[r_wr_bank] <= '0;
               end
            end
            S_FILL: begin
               if (i_read_done) begin
                  r_state     <= S_DRAIN;
                  r_reader_en <= 1'b0;
               end
            end
            S_DRAIN: begin
               r_state        <= S_COMMIT;
               r_reader_clear <= 1'b1;
            end
            S_COMMIT: begin
               r_row_cnt  <= '0;
               r_col_cnt  <= '0;
               r_word_cnt <= '0;
               r_wr_bank  <= w_other_bank;
               if (!r_full[w_other_bank] && i_en) begin
                  r_state              <= S_FILL;
                  r_reader_en          <= 1'b1;
                  r_bank[w_other_bank] <= '0;
               end else if (r_full[w_other_bank]) begin
                  r_state   <= S_STALL;
                  r_release <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_STALL: begin
               // Full flag must read clear for one cycle before the reader restarts.
               if (r_release) begin
                  r_state           <= S_FILL;
                  r_reader_en       <= 1'b1;
                  r_release         <= 1'b0;
                  r_bank[r_wr_bank] <= '0;
               end else begin
                  r_release <= ~r_full[r_wr_bank];
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_reader_en <= 1'b0;
            end
         endcase

         if (w_accept) begin
            r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
            if (i_addr != i_base_addr + r_word_cnt) begin
               r_addr_err <= 1'b1;
            end
            if (w_room) begin
               r_bank[r_wr_bank][r_row_cnt[RIW-1:0]][r_col_cnt] <= i_data;
               if (w_col_last) begin
                  r_col_cnt <= '0;
                  r_row_cnt <= r_row_cnt + RCW'(1);
               end else begin
                  r_col_cnt <= r_col_cnt + CW'(1);
               end
            end else begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   // Reader side: full flags, read pointer and the registered row output.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_full     <= '0;
         r_rd_bank  <= 1'b0;
         r_rd_row   <= '0;
         r_row_data <= '0;
      end else if (i_reg_clear) begin
         r_full     <= '0;
         r_rd_bank  <= 1'b0;
         r_rd_row   <= '0;
         r_row_data <= '0;
      end else begin
         r_full     <= w_full_nxt;
         r_rd_bank  <= w_rd_bank_nxt;
         r_rd_row   <= w_rd_row_nxt;
         r_row_data <= w_full_nxt[w_rd_bank_nxt] ? w_row_sel : '0;
      end
   end

   assign o_reader_en    = r_reader_en;
   assign o_reader_clear = r_reader_clear;
   assign o_row_data     = r_row_data;
   assign o_row_idx      = r_rd_row;
   assign o_row_valid    = r_full[r_rd_bank];
   assign o_row_last     = (r_rd_row == RIW'(ROWS - 1));
   assign o_overflow     = r_overflow;
   assign o_addr_err     = r_addr_err;

endmodule
